niosii_system_sysid_info: RTL

Parametrised system-identification and info slave on the Avalon-MM bus of the Nios II system. It is read-mostly and exposes:
- build constants: system ID, timestamp, version/feature word;
- a software scratch register;
- a free-running uptime counter, with coherent 64-bit readout through a snapshot;
- NUM_USER user status words.
Registered read, fixed 1-cycle latency, readdatavalid handshake.

---
 rtl/niosii_system_sysid_info_pkg.sv | 37 +++
 rtl/niosii_system_sysid_info_uptime.sv | 37 +++
 rtl/niosii_system_sysid_info.sv | 126 ++++++++++++
 3 files changed

// File: rtl/niosii_system_sysid_info_pkg.sv
// Shared register map, CTRL bit positions, INFO field layout and the
// byte-lane merge used by the writable registers of the sysid/info slave.
package niosII_system_sysid_pkg;

    localparam int unsigned ADDR_SYS_ID    = 0;
    localparam int unsigned ADDR_TIMESTAMP = 1;
    localparam int unsigned ADDR_INFO      = 2;
    localparam int unsigned ADDR_SCRATCH   = 3;
    localparam int unsigned ADDR_UPTIME_LO = 4;
    localparam int unsigned ADDR_UPTIME_HI = 5;
    localparam int unsigned ADDR_CTRL      = 6;
    localparam int unsigned ADDR_RESERVED  = 7;
    localparam int unsigned ADDR_USER_BASE = 8;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_FREEZE = 1;

    localparam int INFO_VERSION_LSB  = 16;
    localparam int INFO_NUM_USER_LSB = 8;
    localparam int INFO_ADDR_W_LSB   = 0;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_value,
        input logic [31:0] new_value,
        input logic [3:0]  lanes
    );
        logic [31:0] merged;
        merged = old_value;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) begin
                merged[8*b +: 8] = new_value[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/niosii_system_sysid_info_uptime.sv
// Free-running uptime counter with clear/freeze control and a snapshot of
// the upper bits taken whenever software reads the low word.
module niosII_system_sysid_uptime #(
    parameter int                  UPTIME_W    = 64,
    parameter logic [UPTIME_W-1:0] UPTIME_INIT = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    input  logic        snapshot_load,
    output logic [31:0] count_lo,
    output logic [31:0] snapshot
);

    logic [UPTIME_W-1:0] count;

    // Clear wins over freeze; the counter wraps silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= UPTIME_INIT;
            snapshot <= '0;
        end else begin
            if (clear) begin
                count <= '0;
            end else if (!freeze) begin
                count <= count + UPTIME_W'(1);
            end
            if (snapshot_load) begin
                snapshot <= 32'(count >> 32);
            end
        end
    end

    assign count_lo = count[31:0];

endmodule

// File: rtl/niosii_system_sysid_info.sv
// Avalon-MM system-identification slave: build constants, scratch, uptime,
// control and staged user status words, with a fixed one-cycle read latency.
module niosii_system_sysid_info
    import niosII_system_sysid_pkg::*;
#(
    parameter logic [31:0]         SYS_ID      = 32'h0000_0000,
    parameter logic [31:0]         TIMESTAMP   = 32'h0000_0000,
    parameter logic [15:0]         VERSION     = 16'h0001,
    parameter int                  NUM_USER    = 4,
    parameter int                  ADDR_W      = 4,
    parameter int                  UPTIME_W    = 64,
    parameter logic [UPTIME_W-1:0] UPTIME_INIT = '0
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [ADDR_W-1:0]                             address,
    input  logic                                          read,
    input  logic                                          write,
    input  logic [31:0]                                   writedata,
    input  logic [3:0]                                    byteenable,
    output logic [31:0]                                   readdata,
    output logic                                          readdatavalid,
    input  logic [((NUM_USER > 0) ? NUM_USER*32 : 32)-1:0] user_status
);

    localparam int USER_BITS = (NUM_USER > 0) ? NUM_USER*32 : 32;
    localparam logic [31:0] INFO_WORD =
        (32'(VERSION) << INFO_VERSION_LSB) |
        (32'(8'(NUM_USER)) << INFO_NUM_USER_LSB) |
        (32'(8'(ADDR_W)) << INFO_ADDR_W_LSB);

    if (NUM_USER < 0 || NUM_USER > (2**ADDR_W) - 8) begin : g_bad_num_user
        $error("NUM_USER=%0d does not fit in a %0d-bit address map", NUM_USER, ADDR_W);
    end
    if (UPTIME_W < 33 || UPTIME_W > 64) begin : g_bad_uptime_w
        $error("UPTIME_W=%0d outside 33..64", UPTIME_W);
    end

    logic [31:0]          addr_ext;
    logic [31:0]          scratch;
    logic                 ctrl_freeze;
    logic [USER_BITS-1:0] user_stage;
    logic [31:0]          uptime_lo;
    logic [31:0]          uptime_snapshot;
    logic [31:0]          read_value;
    logic [31:0]          readdata_q;
    logic                 readdatavalid_q;
    logic                 write_scratch;
    logic                 write_ctrl;
    logic                 clear_uptime;
    logic                 snap_uptime;
    int unsigned          user_index;

    assign addr_ext      = 32'(address);
    assign write_scratch = write && (addr_ext == ADDR_SCRATCH);
    assign write_ctrl    = write && (addr_ext == ADDR_CTRL);
    assign clear_uptime  = write_ctrl && byteenable[0] && writedata[CTRL_CLEAR];
    assign snap_uptime   = read && (addr_ext == ADDR_UPTIME_LO);

    niosII_system_sysid_uptime #(
        .UPTIME_W    (UPTIME_W),
        .UPTIME_INIT (UPTIME_INIT)
    ) u_uptime (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear_uptime),
        .freeze        (ctrl_freeze),
        .snapshot_load (snap_uptime),
        .count_lo      (uptime_lo),
        .snapshot      (uptime_snapshot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch     <= '0;
            ctrl_freeze <= 1'b0;
            user_stage  <= '0;
        end else begin
            user_stage <= user_status;
            if (write_scratch) begin
                scratch <= merge_bytes(scratch, writedata, byteenable);
            end
            if (write_ctrl && byteenable[0]) begin
                ctrl_freeze <= writedata[CTRL_FREEZE];
            end
        end
    end

    // The mux sees register state before this cycle's write lands.
    always_comb begin
        read_value = '0;
        user_index = addr_ext - ADDR_USER_BASE;
        case (addr_ext)
            ADDR_SYS_ID:    read_value = SYS_ID;
            ADDR_TIMESTAMP: read_value = TIMESTAMP;
            ADDR_INFO:      read_value = INFO_WORD;
            ADDR_SCRATCH:   read_value = scratch;
            ADDR_UPTIME_LO: read_value = uptime_lo;
            ADDR_UPTIME_HI: read_value = uptime_snapshot;
            ADDR_CTRL:      read_value[CTRL_FREEZE] = ctrl_freeze;
            ADDR_RESERVED:  read_value = '0;
            default: begin
                if (addr_ext >= ADDR_USER_BASE && user_index < NUM_USER) begin
                    read_value = user_stage[user_index*32 +: 32];
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdatavalid_q <= read;
            if (read) begin
                readdata_q <= read_value;
            end
        end
    end

    // A reset arriving the cycle after a read drops that read's response.
    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q & ~reset;

endmodule
